mul4_rr_arbiter: RTL and testbench

- Shares one combinational 4x4 unsigned multiplier (`multiplier_4bit`) among NREQ requesters.
- Arbitration is round-robin; each requester uses a valid/ready handshake on its input side.
- The product is registered and returned with the requester ID on a single valid/ready response channel.
- Sits between several issuing blocks and the multiplier datapath, so the datapath is not replicated.

---
 rtl/mul4_arb_pkg.sv | 13 +
 rtl/multiplier_4bit.sv | 13 +
 rtl/mul4_rr_arbiter.sv | 129 ++++++++++++
 tb/tb_mul4_rr_arbiter.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mul4_arb_pkg.sv
// Shared types and widths for the shared-multiplier round-robin arbiter.
package mul4_arb_pkg;

    // Output register occupancy: IDLE = empty, HOLD = product waiting downstream.
    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    localparam int OP_W   = 4;
    localparam int PROD_W = 8;

endpackage

// File: rtl/multiplier_4bit.sv
// Combinational unsigned 4x4 -> 8 multiplier shared by all requesters.
module multiplier_4bit
    import mul4_arb_pkg::*;
(
    input  logic [OP_W-1:0]   a,
    input  logic [OP_W-1:0]   b,
    output logic [PROD_W-1:0] p
);

    // Zero-extend both operands so the full 8-bit product is kept.
    assign p = {{(PROD_W-OP_W){1'b0}}, a} * {{(PROD_W-OP_W){1'b0}}, b};

endmodule

// File: rtl/mul4_rr_arbiter.sv
// Round-robin arbiter sharing one 4x4 multiplier among NREQ requesters.
// The granted request is multiplied combinationally and the product is
// registered with the requester ID on a single valid/ready response channel.
module mul4_rr_arbiter
    import mul4_arb_pkg::*;
#(
    parameter  int NREQ = 4,
    localparam int IDW  = $clog2(NREQ)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [OP_W*NREQ-1:0] req_a,
    input  logic [OP_W*NREQ-1:0] req_b,
    output logic [NREQ-1:0]      req_ready,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [PROD_W-1:0]    rsp_prod,
    output logic [IDW-1:0]       rsp_id,
    output logic [15:0]          ops_done
);

    state_t            state;
    state_t            state_next;
    logic [IDW-1:0]    rr_ptr;
    logic [IDW-1:0]    grant_idx;
    logic [IDW-1:0]    scan_idx;
    logic [IDW:0]      scan_sum;
    logic              any_valid;
    logic [NREQ-1:0]   grant_oh;
    logic              can_accept;
    logic              accept;
    logic              consume;
    logic [OP_W-1:0]   a_sel;
    logic [OP_W-1:0]   b_sel;
    logic [PROD_W-1:0] prod;
    logic [IDW-1:0]    ptr_next;

    // A new request can be taken when the output register is empty or is being drained this cycle.
    assign can_accept = (state == IDLE) || (state == HOLD && rsp_ready);
    assign accept     = can_accept && any_valid;
    assign consume    = (state == HOLD) && rsp_ready;
    assign rsp_valid  = (state == HOLD);

    // Scan from rr_ptr upward (mod NREQ); walking k downward lets the smallest k win.
    always_comb begin
        grant_idx = '0;
        any_valid = 1'b0;
        scan_sum  = '0;
        scan_idx  = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            scan_sum = {1'b0, rr_ptr} + (IDW+1)'(k);
            if (scan_sum >= (IDW+1)'(NREQ)) begin
                scan_sum = scan_sum - (IDW+1)'(NREQ);
            end
            scan_idx = scan_sum[IDW-1:0];
            if (req_valid[scan_idx]) begin
                grant_idx = scan_idx;
                any_valid = 1'b1;
            end
        end
    end

    // One-hot accept, suppressed during reset and while the held result is blocked.
    always_comb begin
        grant_oh = '0;
        grant_oh[grant_idx] = 1'b1;
        req_ready = (accept && !rst) ? grant_oh : '0;
    end

    // Route the granted requester's operands to the shared multiplier.
    always_comb begin
        a_sel = '0;
        b_sel = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (IDW'(i) == grant_idx) begin
                a_sel = req_a[i*OP_W +: OP_W];
                b_sel = req_b[i*OP_W +: OP_W];
            end
        end
    end

    multiplier_4bit u_mul (
        .a (a_sel),
        .b (b_sel),
        .p (prod)
    );

    assign ptr_next = (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;

    // Next-state: an accept always (re)fills the register; otherwise a drain empties it.
    always_comb begin
        state_next = state;
        if (accept) begin
            state_next = HOLD;
        end else if (consume) begin
            state_next = IDLE;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Response register, rotation pointer and consumed-response counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr   <= '0;
            rsp_prod <= '0;
            rsp_id   <= '0;
            ops_done <= '0;
        end else begin
            if (accept) begin
                rsp_prod <= prod;
                rsp_id   <= grant_idx;
                rr_ptr   <= ptr_next;
            end
            if (consume) begin
                ops_done <= ops_done + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_mul4_rr_arbiter.sv
// Self-checking bench for mul4_rr_arbiter: directed scenarios followed by
// randomized traffic, all compared against a transaction-level reference model.
module tb_mul4_rr_arbiter;

    localparam int NREQ = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid;
    logic [15:0] req_a;
    logic [15:0] req_b;
    logic [3:0]  req_ready;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [7:0]  rsp_prod;
    logic [1:0]  rsp_id;
    logic [15:0] ops_done;

    int errors = 0;
    int checks = 0;

    // Reference model state: output slot contents, rotation start, consumed count.
    bit          m_hold;
    logic [7:0]  m_prod;
    logic [1:0]  m_id;
    int          m_ptr;
    logic [15:0] m_ops;
    logic [3:0]  m_last_rdy;

    mul4_rr_arbiter #(.NREQ(NREQ)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_prod  (rsp_prod),
        .rsp_id    (rsp_id),
        .ops_done  (ops_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // First valid requester found walking forward from ptr, or -1 if none.
    function automatic int model_grant(input int ptr, input logic [3:0] v);
        for (int k = 0; k < NREQ; k++) begin
            if (v[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_hold     = 1'b0;
        m_prod     = 8'd0;
        m_id       = 2'd0;
        m_ptr      = 0;
        m_ops      = 16'd0;
        m_last_rdy = 4'd0;
    endtask

    // Called at posedge+1 with inputs already driven; checks req_ready before the
    // edge, advances the model at the edge, then checks registered outputs.
    task automatic cycle(input string tag, input bit do_chk);
        int         g;
        int         av;
        int         bv;
        bit         can;
        logic [3:0] exp_rdy;
        #3;
        g   = model_grant(m_ptr, req_valid);
        can = !m_hold || (rsp_ready === 1'b1);
        exp_rdy = 4'd0;
        if (!rst && can && g >= 0) exp_rdy = 4'(1 << g);
        if (do_chk) chk({tag, "_ready"}, 32'(req_ready), 32'(exp_rdy));
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            if (m_hold && rsp_ready) m_ops = m_ops + 16'd1;
            if (can && g >= 0) begin
                av     = int'((req_a >> (4 * g)) & 16'hF);
                bv     = int'((req_b >> (4 * g)) & 16'hF);
                m_prod = 8'(av * bv);
                m_id   = 2'(g);
                m_ptr  = (g + 1) % NREQ;
                m_hold = 1'b1;
            end else if (m_hold && rsp_ready) begin
                m_hold = 1'b0;
            end
            m_last_rdy = exp_rdy;
        end
        #1;
        if (do_chk) begin
            chk({tag, "_valid"}, 32'(rsp_valid), 32'(m_hold));
            chk({tag, "_prod"},  32'(rsp_prod),  32'(m_prod));
            chk({tag, "_id"},    32'(rsp_id),    32'(m_id));
            chk({tag, "_ops"},   32'(ops_done),  32'(m_ops));
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cycle("rst", 1);
        rst = 1'b0;
    endtask

    // Requesters keep a pending request until it is accepted, then may re-randomize.
    task automatic rand_reqs();
        for (int i = 0; i < NREQ; i++) begin
            if (!req_valid[i] || m_last_rdy[i]) begin
                req_valid[i]     = 1'($urandom_range(0, 1));
                req_a[i*4 +: 4]  = 4'($urandom_range(0, 15));
                req_b[i*4 +: 4]  = 4'($urandom_range(0, 15));
            end
        end
    endtask

    initial begin
        int guard;
        model_reset();

        // Reset with every requester asking.
        rst       = 1'b1;
        req_valid = 4'hF;
        req_a     = 16'h4321;
        req_b     = 16'h5678;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        cycle("rst_a", 1);
        cycle("rst_b", 1);
        chk("rst_prod_zero", 32'(rsp_prod), 32'd0);
        chk("rst_ops_zero",  32'(ops_done), 32'd0);

        // Single request from requester 0: 14*13.
        rst       = 1'b0;
        req_valid = 4'b0001;
        req_a     = 16'h000E;
        req_b     = 16'h000D;
        rsp_ready = 1'b1;
        cycle("single", 1);
        chk("single_prod_182", 32'(rsp_prod), 32'd182);
        chk("single_id_0",     32'(rsp_id),   32'd0);
        req_valid = 4'b0000;
        cycle("single_drain", 1);
        chk("single_ops_1", 32'(ops_done), 32'd1);

        // Fairness: all valid, A=i+1, B=15.
        do_reset();
        req_valid = 4'hF;
        req_a     = 16'h4321;
        req_b     = 16'hFFFF;
        rsp_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cycle("fair", 1);
            chk("fair_id",   32'(rsp_id),   32'(i % 4));
            chk("fair_prod", 32'(rsp_prod), 32'(15 * (i % 4 + 1)));
        end
        chk("fair_ops_4", 32'(ops_done), 32'd4);

        // Backpressure: requester 2 gets 14*15 and is held for 5 cycles.
        do_reset();
        req_valid = 4'b0100;
        req_a     = 16'h0E00;
        req_b     = 16'h0F00;
        rsp_ready = 1'b0;
        cycle("bp_accept", 1);
        req_valid = 4'hF;
        for (int i = 0; i < 5; i++) begin
            cycle("bp_hold", 1);
            chk("bp_prod_210", 32'(rsp_prod), 32'd210);
            chk("bp_id_2",     32'(rsp_id),   32'd2);
        end
        rsp_ready = 1'b1;
        #1;
        chk("bp_release_ready", 32'(req_ready), 32'h8);
        cycle("bp_release", 1);
        chk("bp_release_id_3", 32'(rsp_id), 32'd3);

        // Operand corners.
        do_reset();
        req_valid = 4'b0001;
        req_a     = 16'h000F;
        req_b     = 16'h000F;
        cycle("corner_max", 1);
        chk("corner_225", 32'(rsp_prod), 32'd225);
        req_a     = 16'h0000;
        req_b     = 16'h0009;
        cycle("corner_zero", 1);
        chk("corner_0", 32'(rsp_prod), 32'd0);

        // ops_done wrap: one consume per cycle until the counter rolls over.
        do_reset();
        req_valid = 4'hF;
        req_a     = 16'h9A5C;
        req_b     = 16'h37E1;
        rsp_ready = 1'b1;
        guard     = 0;
        while (m_ops != 16'hFFFF && guard < 70000) begin
            cycle("wrap", 0);
            guard++;
        end
        chk("wrap_reached", 32'(guard < 70000), 32'd1);
        chk("wrap_ffff", 32'(ops_done), 32'hFFFF);
        cycle("wrap_step", 1);
        chk("wrap_zero", 32'(ops_done), 32'd0);

        // Reset while a result is held.
        do_reset();
        req_valid = 4'b0001;
        req_a     = 16'h0003;
        req_b     = 16'h0005;
        rsp_ready = 1'b0;
        cycle("mid_fill", 1);
        rst = 1'b1;
        cycle("mid_rst", 1);
        chk("mid_valid_0", 32'(rsp_valid), 32'd0);
        chk("mid_ops_0",   32'(ops_done),  32'd0);
        rst       = 1'b0;
        req_valid = 4'b0110;
        rsp_ready = 1'b1;
        cycle("mid_after", 1);
        chk("mid_first_id_1", 32'(rsp_id), 32'd1);

        // Randomized traffic with occasional resets.
        do_reset();
        req_valid = 4'h0;
        for (int n = 0; n < 400; n++) begin
            rand_reqs();
            rsp_ready = 1'($urandom_range(0, 3) != 0);
            rst       = ($urandom_range(0, 39) == 0);
            cycle("rand", 1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
